// File: rtl/chunked_add_sub_if.sv
// Request/result bundle for chunked_add_sub: start/ready capture handshake
// and valid/ack result handshake.
interface chunked_add_sub_if #(parameter int WIDTH = 16);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, cin, a, b, ack,
                  input  ready, valid, sum, cout, ovf);
  modport slave  (input  start, sub, cin, a, b, ack,
                  output ready, valid, sum, cout, ovf);
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/sub: CHUNK bits per clock through one adder slice with a
// registered carry. Define CHUNKED_ADD_SUB_SAT_EN for signed saturation.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  chunked_add_sub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_out, c_msb_in, ovf_now;
  int               base;

  // One CHUNK-bit slice; carry into the slice MSB is recovered from the
  // MSB sum bit, which keeps CHUNK=1 working without a special case.
  always_comb begin
    base     = int'(cnt_q) * CHUNK;
    a_ch     = a_q[base +: CHUNK];
    b_ch     = b_q[base +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    c_msb_in = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    ovf_now  = c_msb_in ^ c_out;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = s_ch;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          // Subtract runs as a + ~b + ~cin, so a missing carry is a borrow.
          cout_d  = c_out ^ sub_q;
          ovf_d   = ovf_now;
`ifdef CHUNKED_ADD_SUB_SAT_EN
          if (ovf_now)
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end
      end
      DONE: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.valid = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub (WIDTH=16, CHUNK=4): directed table, handshake
// corner cases, mid-run reset and randomized ops against an arithmetic model.
module tb_chunked_add_sub;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  chunked_add_sub_if #(.WIDTH(W)) bus ();

  chunked_add_sub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference computed from plain integer arithmetic on the whole operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic c, output logic [W-1:0] r, output logic co,
                       output logic ov);
    int sa, sb, full, res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      full = int'(a) + int'(b) + int'(c);
      co   = (full > 65535);
      res  = sa + sb + int'(c);
    end else begin
      full = int'(a) - int'(b) - int'(c);
      co   = (full < 0);
      res  = sa - sb - int'(c);
    end
    r  = full[W-1:0];
    ov = (res > 32767) || (res < -32768);
`ifdef CHUNKED_ADD_SUB_SAT_EN
    if (ov) r = (res < 0) ? 16'h8000 : 16'h7FFF;
`endif
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] es,
                        input logic ec, input logic eo, input int hold, input bit noise);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.sub = 1'($urandom); bus.cin = 1'($urandom);
    chk({nm, "_busy"}, 32'(bus.ready), 32'd0);
    lat = 0;
    while (!bus.valid && lat < 20) begin
      bus.start = noise && (lat == 1);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({nm, "_lat"},  32'(lat), 32'd4);
    chk({nm, "_sum"},  32'(bus.sum), 32'(es));
    chk({nm, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({nm, "_ovf"},  32'(bus.ovf), 32'(eo));
    repeat (hold) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(bus.valid), 32'd1);
      chk({nm, "_hold_sum"},   32'(bus.sum), 32'(es));
    end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk({nm, "_ack_ready"}, 32'(bus.ready), 32'd1);
    chk({nm, "_ack_valid"}, 32'(bus.valid), 32'd0);
    chk({nm, "_ack_sum"},   32'(bus.sum), 32'(es));
  endtask

  vec_t         vt[8];
  logic [W-1:0] ra, rb, es;
  logic         rs, rc, ec, eo;

  initial begin
    tests = 0; fails = 0;
    vt[0] = '{"add_basic", 16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0};
    vt[1] = '{"add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{"add_cin",   16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
`ifdef CHUNKED_ADD_SUB_SAT_EN
    vt[3] = '{"add_povf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[5] = '{"sub_novf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[7] = '{"add_nn",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    vt[3] = '{"add_povf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[5] = '{"sub_novf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[7] = '{"add_nn",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
    vt[4] = '{"sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vt[6] = '{"sub_bin",    16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.ack = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.a = '0; bus.b = '0;
    #12;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_sum",   32'(bus.sum), 32'd0);
    chk("rst_cout",  32'(bus.cout), 32'd0);
    chk("rst_ovf",   32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i])
      run_op(vt[i].name, vt[i].a, vt[i].b, vt[i].sub, vt[i].cin,
             vt[i].sum, vt[i].cout, vt[i].ovf, 0, 1'b0);

    // Extra start mid-run must be ignored; long ack hold keeps result.
    run_op("noise_hold", 16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0, 10, 1'b1);

    // Ack while idle does nothing.
    @(negedge clk);
    bus.ack = 1'b1;
    repeat (2) @(negedge clk);
    bus.ack = 1'b0;
    chk("idle_ack_ready", 32'(bus.ready), 32'd1);
    chk("idle_ack_valid", 32'(bus.valid), 32'd0);

    // Start and ack together in DONE: ack wins, start dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0003; bus.b = 16'h0004; bus.sub = 1'b0; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("sa_valid", 32'(bus.valid), 32'd1);
    chk("sa_sum",   32'(bus.sum), 32'h7);
    bus.start = 1'b1; bus.ack = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0; bus.ack = 1'b0;
    chk("sa_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    chk("sa_still_idle", 32'(bus.ready), 32'd1);
    chk("sa_sum_kept",   32'(bus.sum), 32'h7);

    // Async reset landing on the second RUN edge aborts the op.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hABCD; bus.b = 16'h1111; bus.sub = 1'b0; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_sum",   32'(bus.sum), 32'd0);
    chk("mid_rst_flags", 32'({bus.cout, bus.ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", 32'(bus.valid), 32'd0);
    run_op("post_rst", 16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      if (n % 10 == 0) rb = rs ? ra : ~ra;
      model(ra, rb, rs, rc, es, ec, eo);
      run_op("rand", ra, rb, rs, rc, es, ec, eo, $urandom_range(0, 2), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/chunked_add_sub.md
Name: chunked_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the single-bit full adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through a CHUNK-bit adder slice with a registered inter-chunk carry.
- Computes a+b+cin or a-b-borrow, with carry/borrow-out and signed overflow flags.
- Used where a full-width single-cycle carry chain is too slow or too large; start/valid/ack handshake.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits added per clock cycle; 1 gives a fully bit-serial adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in (add) or borrow-in (sub); captured with start.
- ready  output  1  high in IDLE only.
- valid  output  1  result valid; held until ack.
- ack  input  1  consumer accepts result; meaningful only while valid=1.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) or borrow-out (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Definitions: N = WIDTH/CHUNK. Chunk k is bits [k*CHUNK +: CHUNK]. Chunk 0 is the LSB chunk and is processed first.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready=1, valid=0, sum=0, cout=0, ovf=0.
  - Internal operand registers, carry register and chunk counter cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; no partial result is reported.
- States and transitions:
  - IDLE -> RUN on start=1. At that edge: capture a, b-or-~b, sub, and the initial carry (cin if sub=0, ~cin if sub=1); clear the counter.
  - RUN: each edge adds chunk k of A, chunk k of B', and the carry register. It writes the CHUNK-bit result into sum chunk k, updates the carry register and increments k. At the edge processing k=N-1, go to DONE and set valid=1.
  - DONE -> IDLE on ack=1. That edge clears valid; sum, cout and ovf keep their values until the next operation's first RUN edge.
- Latency: valid rises exactly N rising edges after the edge that accepted start. Example: WIDTH=16, CHUNK=4 gives 4 edges.
- Throughput: one operation per N+2 cycles minimum (capture, N chunks, ack).
- Flag rules:
  - cout = final carry when sub=0; ~final carry when sub=1, i.e. borrow.
  - ovf = carry into MSB XOR carry out of MSB, evaluated on the final chunk.
- Result semantics: sub=1 computes a - b - cin modulo 2^WIDTH.
- Handshake corner cases:
  - start while ready=0 is ignored; inputs are not captured.
  - ack while valid=0 is ignored.
  - start and ack in the same cycle in DONE: the ack is honoured, and the start is ignored because ready=0 that cycle.
- Operand stability: a, b, sub and cin may change freely after the accepting edge.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CHUNKED_ADD_SUB_SAT_EN.
- Defined: when ovf=1 on the final chunk, the fully written sum is replaced at that same edge by the signed limit.
  - Positive overflow gives 0111..1; negative overflow gives 1000..0. The sign is that of operand A.
  - ovf still reports 1; cout is unchanged. Latency is unchanged.
- Not defined: sum wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan (WIDTH=16, CHUNK=4):
- Add, a=0x1234, b=0x0FF1, cin=0 -> valid 4 edges after start; sum=0x2225, cout=0, ovf=0. Ack returns ready=1 next cycle.
- Add, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. A cin=1 variant with a=0x00FF, b=0x0000 gives sum=0x0100.
- Add, a=0x7FFF, b=0x0001 -> ovf=1, cout=0, sum=0x8000. With CHUNKED_ADD_SUB_SAT_EN, sum=0x7FFF.
- Sub, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout(borrow)=1, ovf=0. Sub, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1; with the SAT macro, sum=0x8000.
- Start pulsed again during RUN with different operands -> ignored, result still correct. Holding ack=0 for 10 cycles keeps valid=1 and sum stable.
- rst_n dropped at the second RUN edge -> outputs immediately 0, ready=1. A new start completes normally with the correct result.
